// File: rtl/emds_pkg.sv
// emds_pkg: shared FSM state type and default message size for msg_byte_sequencer
package emds_pkg;

    localparam int MSG_BYTES_DEFAULT = 100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/msg_byte_sequencer.sv
// msg_byte_sequencer: streams a captured message byte-by-byte through a cipher core and reassembles the results (NUL_TERMINATE_EN: stop at first 8'h00)
module msg_byte_sequencer
    import emds_pkg::*;
#(
    parameter int MSG_BYTES = MSG_BYTES_DEFAULT
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [8*MSG_BYTES-1:0]         in_message,
    output logic                           core_in_valid,
    output logic [7:0]                     core_in_byte,
    input  logic                           core_in_ready,
    input  logic                           core_out_valid,
    input  logic [7:0]                     core_out_byte,
    output logic [8*MSG_BYTES-1:0]         out_message,
    output logic [$clog2(MSG_BYTES+1)-1:0] byte_count,
    output logic                           busy,
    output logic                           done
);

    localparam int MW = 8 * MSG_BYTES;
    localparam int IW = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
    localparam int CW = $clog2(MSG_BYTES + 1);

    state_t        state_q, state_d;
    logic [MW-1:0] buf_q, buf_d;
    logic [MW-1:0] out_q, out_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    cur_byte;
    logic          nul;

    assign cur_byte = buf_q[8*idx_q +: 8];

`ifdef NUL_TERMINATE_EN
    assign nul = (cur_byte == 8'h00);
`else
    assign nul = 1'b0;
`endif

    // next-state, byte select/insert and handshake outputs
    always_comb begin
        state_d       = state_q;
        buf_d         = buf_q;
        out_d         = out_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        core_in_valid = 1'b0;
        core_in_byte  = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    buf_d   = in_message;
                    out_d   = '0;
                    cnt_d   = '0;
                    idx_d   = IW'(MSG_BYTES - 1);
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (nul) begin
                    state_d = S_DONE;
                end else begin
                    core_in_valid = 1'b1;
                    core_in_byte  = cur_byte;
                    if (core_in_ready) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (core_out_valid) begin
                    out_d[8*idx_q +: 8] = core_out_byte;
                    cnt_d               = cnt_q + CW'(1);
                    if (idx_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q - IW'(1);
                        state_d = S_SEND;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state registers; reset wins over every other input
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            out_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_message = out_q;
    assign byte_count  = cnt_q;
    assign busy        = (state_q == S_SEND) || (state_q == S_WAIT);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_msg_byte_sequencer.sv
// tb_msg_byte_sequencer: table-driven runs against an XOR-0x20 core model with a done-time scoreboard
module tb_msg_byte_sequencer;

    localparam int MB = 4;

    typedef struct {
        logic [8*MB-1:0] msg;
        int              dly;
        bit              spur;
        bit              restart;
        logic [8*MB-1:0] exp_out;
        int              exp_cnt;
        int              exp_lat;
    } vec_t;

    typedef struct {
        logic [8*MB-1:0] out;
        int              cnt;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic [8*MB-1:0] in_message;
    logic            core_in_valid;
    logic [7:0]      core_in_byte;
    logic            core_in_ready;
    logic            core_out_valid;
    logic [7:0]      core_out_byte;
    logic [8*MB-1:0] out_message;
    logic [2:0]      byte_count;
    logic            busy;
    logic            done;

    int   errs = 0;
    int   checks = 0;
    int   dly = 0;
    bit   spur_en = 1'b0;
    logic pend = 1'b0;
    logic [7:0] pend_byte = 8'h00;
    int   hold_cnt = 0;
    exp_t sb[$];
    vec_t vecs[6];

    always #5 clock = ~clock;

    msg_byte_sequencer #(.MSG_BYTES(MB)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .in_message(in_message),
        .core_in_valid(core_in_valid),
        .core_in_byte(core_in_byte),
        .core_in_ready(core_in_ready),
        .core_out_valid(core_out_valid),
        .core_out_byte(core_out_byte),
        .out_message(out_message),
        .byte_count(byte_count),
        .busy(busy),
        .done(done)
    );

    assign core_in_ready  = core_in_valid && (hold_cnt >= dly);
    assign core_out_valid = pend | (spur_en & (core_in_valid | ~busy));
    assign core_out_byte  = pend ? pend_byte : 8'hEE;

    // cipher core model: accepts after dly stalled cycles, answers on the next cycle
    always @(posedge clock) begin
        pend      <= !reset && core_in_valid && core_in_ready;
        pend_byte <= core_in_byte ^ 8'h20;
        hold_cnt  <= (core_in_valid && !core_in_ready && !reset) ? hold_cnt + 1 : 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " out"}, out_message, 0);
        chk({tag, " cnt"}, 32'(byte_count), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " in_valid"}, 32'(core_in_valid), 0);
        chk({tag, " in_byte"}, 32'(core_in_byte), 0);
    endtask

    task automatic run(input vec_t v, input int n);
        int         cyc;
        bit         hold;
        logic [7:0] hb;
        exp_t       e;
        dly        = v.dly;
        spur_en    = v.spur;
        in_message = v.msg;
        @(negedge clock);
        start = 1'b1;
        sb.push_back('{v.exp_out, v.exp_cnt});
        @(posedge clock);
        #1;
        start = 1'b0;
        cyc   = 1;
        hold  = 1'b0;
        hb    = 8'h00;
        chk($sformatf("v%0d busy_after_start", n), 32'(busy), 1);
        while (!done && cyc < 200) begin
            if (v.restart && cyc == 3) begin
                start      = 1'b1;
                in_message = "WXYZ";
            end else if (v.restart && cyc == 4) begin
                start = 1'b0;
            end
            if (hold) begin
                chk($sformatf("v%0d valid_held", n), 32'(core_in_valid), 1);
                chk($sformatf("v%0d byte_stable", n), 32'(core_in_byte), 32'(hb));
            end
            hold = core_in_valid && !core_in_ready;
            hb   = core_in_byte;
            @(posedge clock);
            #1;
            cyc++;
        end
        start = 1'b0;
        if (!done) begin
            checks++;
            errs++;
            $display("FAIL v%0d timeout: no done after %0d cycles, required one", n, cyc);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d out_message", n), out_message, e.out);
            chk($sformatf("v%0d byte_count", n), 32'(byte_count), 32'(e.cnt));
            if (v.exp_lat != 0) chk($sformatf("v%0d done_cycle", n), 32'(cyc), 32'(v.exp_lat));
            @(posedge clock);
            #1;
            chk($sformatf("v%0d done_one_cycle", n), 32'(done), 0);
            chk($sformatf("v%0d idle_busy", n), 32'(busy), 0);
            chk($sformatf("v%0d out_hold", n), out_message, e.out);
        end
        spur_en = 1'b0;
    endtask

    initial begin
        int cyc;
        vecs[0] = '{"ABCD", 0, 1'b0, 1'b0, "abcd", 4, 9};
        vecs[1] = '{"ABCD", 3, 1'b0, 1'b0, "abcd", 4, 21};
`ifdef NUL_TERMINATE_EN
        vecs[2] = '{{"AB", 8'h00, "D"}, 0, 1'b0, 1'b0, {"ab", 16'h0000}, 2, 6};
        vecs[3] = '{32'h0000_0000, 0, 1'b0, 1'b0, 32'h0000_0000, 0, 2};
`else
        vecs[2] = '{{"AB", 8'h00, "D"}, 0, 1'b0, 1'b0, {"ab", 8'h20, "d"}, 4, 9};
        vecs[3] = '{32'h0000_0000, 0, 1'b0, 1'b0, 32'h2020_2020, 4, 9};
`endif
        vecs[4] = '{"wxyz", 1, 1'b1, 1'b0, "WXYZ", 4, 13};
        vecs[5] = '{"ABCD", 2, 1'b0, 1'b1, "abcd", 4, 17};

        reset      = 1'b1;
        start      = 1'b0;
        in_message = '0;
        repeat (3) @(posedge clock);
        #1;
        chk_idle("reset");
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run(vecs[i], i);

        // reset and start in the same cycle: reset wins
        @(negedge clock);
        reset      = 1'b1;
        start      = 1'b1;
        in_message = "QQQQ";
        @(posedge clock);
        #1;
        reset = 1'b0;
        start = 1'b0;
        chk_idle("rst_prio");
        @(posedge clock);
        #1;
        chk("rst_prio stays_idle", 32'(busy), 0);

        // reset mid-run after two bytes complete
        dly        = 0;
        in_message = "ABCD";
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        cyc   = 0;
        while (byte_count != 3'd2 && cyc < 50) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        chk("midrun reached_two", 32'(byte_count), 2);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk_idle("midrun");

        run(vecs[0], 6);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
